// File: rtl/pll_dps_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_dps_sequencer_if
//   Bundles the request handshake, the Cyclone V DPS port and the status
//   outputs of pll_dps_sequencer. Clock and reset stay plain module ports.
//
//   master : requester / PLL side (drives requests, locked, phase_done)
//   slave  : the sequencer (drives ready, DPS controls and status)
//
//   locked      PLL locked
//   req_valid   request strobe            req_ready  high in IDLE only
//   req_cnt     target counter index      req_steps  signed step count
//   phase_en    to PLL phase_en           updn       to PLL updn
//   cntsel      to PLL cntsel             phase_done from PLL phase_done
//   busy        not IDLE                  done       one-cycle completion pulse
//   err         sticky error flag         offset     packed signed net steps
// ---------------------------------------------------------------------------
interface pll_dps_sequencer_if #(
    parameter int NUM_CNT = 3,
    parameter int STEP_W  = 10,
    parameter int ACC_W   = 16
);
    localparam int CNT_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    logic                       locked;
    logic                       req_valid;
    logic                       req_ready;
    logic [CNT_W-1:0]           req_cnt;
    logic signed [STEP_W-1:0]   req_steps;
    logic                       phase_en;
    logic                       updn;
    logic [4:0]                 cntsel;
    logic                       phase_done;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic [NUM_CNT*ACC_W-1:0]   offset;

    modport master (
        output locked, req_valid, req_cnt, req_steps, phase_done,
        input  req_ready, phase_en, updn, cntsel, busy, done, err, offset
    );

    modport slave (
        input  locked, req_valid, req_cnt, req_steps, phase_done,
        output req_ready, phase_en, updn, cntsel, busy, done, err, offset
    );
endinterface

// File: rtl/pll_dps_sequencer.sv
// ---------------------------------------------------------------------------
// pll_dps_sequencer
//   Turns one "shift counter k by N steps" request into N sequential
//   phase_en/phase_done handshakes on the Cyclone V DPS port and keeps a
//   saturating signed net-offset per PLL output counter. Runs on scanclk.
//
//   Ports:
//     scanclk  DPS/scan clock, all logic on its rising edge
//     rst_n    asynchronous active-low reset
//     bus      pll_dps_sequencer_if.slave (request, DPS port, status)
// ---------------------------------------------------------------------------
module pll_dps_sequencer #(
    parameter int NUM_CNT      = 3,
    parameter int STEP_W       = 10,
    parameter int ACC_W        = 16,
    parameter int PH_EN_CYCLES = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic               scanclk,
    input  logic               rst_n,
    pll_dps_sequencer_if.slave bus
);

    localparam int CNT_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
    localparam int PW    = $clog2(PH_EN_CYCLES + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_STEP,
        ST_FIN
    } state_t;

    state_t                   state_q, state_d;
    logic                     locked_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [STEP_W-1:0]        remaining_q;
    logic [PW-1:0]            pulse_cnt_q;
    logic [TW-1:0]            wait_cnt_q;
    logic [4:0]               cntsel_q;
    logic                     updn_q;
    logic                     err_q;
    logic signed [ACC_W-1:0]  off_q [NUM_CNT];
    logic [NUM_CNT*ACC_W-1:0] offset_flat;

    logic                     lock_fall;
    logic                     accept;
    logic                     cnt_bad;
    logic                     steps_zero;
    logic [STEP_W-1:0]        steps_mag;
    logic                     pulse_last;
    logic                     wait_expired;
    logic                     timeout_hit;
    logic                     in_wait;

    // Relock restores the configured phases, so only the falling edge matters.
    assign lock_fall  = locked_q & ~bus.locked;
    assign accept     = bus.req_valid & (state_q == ST_IDLE) & bus.locked;
    assign cnt_bad    = 32'(bus.req_cnt) >= NUM_CNT;
    assign steps_zero = (bus.req_steps == '0);
    // Two's-complement negate in STEP_W bits keeps -2^(STEP_W-1) exact as an
    // unsigned magnitude.
    assign steps_mag  = bus.req_steps[STEP_W-1] ? (~$unsigned(bus.req_steps) + STEP_W'(1))
                                                : $unsigned(bus.req_steps);

    assign pulse_last   = (pulse_cnt_q == PW'(PH_EN_CYCLES - 1));
    assign wait_expired = (wait_cnt_q == TW'(TIMEOUT));
    assign in_wait      = (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);
    assign timeout_hit  = wait_expired &&
                          (((state_q == ST_WAIT_LO) &&  bus.phase_done) ||
                           ((state_q == ST_WAIT_HI) && !bus.phase_done));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge scanclk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (cnt_bad || steps_zero) ? ST_FIN : ST_SETUP;
            end
            ST_SETUP:   state_d = ST_PULSE;
            ST_PULSE: begin
                if (pulse_last) state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!bus.phase_done)  state_d = ST_WAIT_HI;
                else if (timeout_hit) state_d = ST_FIN;
            end
            ST_WAIT_HI: begin
                if (bus.phase_done)   state_d = ST_STEP;
                else if (timeout_hit) state_d = ST_FIN;
            end
            ST_STEP:    state_d = (remaining_q == STEP_W'(1)) ? ST_FIN : ST_SETUP;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // Lock loss aborts an active request; done already pulsed if in FIN.
        if (lock_fall && (state_q != ST_IDLE))
            state_d = (state_q == ST_FIN) ? ST_IDLE : ST_FIN;
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge scanclk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q    <= 1'b0;
            cnt_q       <= '0;
            remaining_q <= '0;
            pulse_cnt_q <= '0;
            wait_cnt_q  <= '0;
            cntsel_q    <= '0;
            updn_q      <= 1'b0;
            err_q       <= 1'b0;
            // NOTE: the offset array is architectural state visible on a port,
            // so it is reset element by element rather than left undefined.
            for (int k = 0; k < NUM_CNT; k++) off_q[k] <= '0;
        end else begin
            locked_q <= bus.locked;

            if (state_q == ST_SETUP)      pulse_cnt_q <= '0;
            else if (state_q == ST_PULSE) pulse_cnt_q <= pulse_cnt_q + PW'(1);

            // Restart on entry to each wait state (any state change clears it).
            if (!in_wait || (state_d != state_q)) wait_cnt_q <= '0;
            else                                  wait_cnt_q <= wait_cnt_q + TW'(1);

            if (accept) begin
                cnt_q       <= bus.req_cnt;
                remaining_q <= steps_mag;
                err_q       <= cnt_bad;
                // Select is loaded here so it is already stable during SETUP.
                if (!cnt_bad && !steps_zero) begin
                    cntsel_q <= 5'(bus.req_cnt);
                    updn_q   <= ~bus.req_steps[STEP_W-1];
                end
            end

            if (timeout_hit) err_q <= 1'b1;
            if (lock_fall && (state_q != ST_IDLE)) err_q <= 1'b1;

            if (state_q == ST_STEP) remaining_q <= remaining_q - STEP_W'(1);

            for (int k = 0; k < NUM_CNT; k++) begin
                if (lock_fall) begin
                    off_q[k] <= '0;
                end else if ((state_q == ST_STEP) && (CNT_W'(k) == cnt_q)) begin
                    if (updn_q && (off_q[k] != ACC_MAX))       off_q[k] <= off_q[k] + ACC_W'(1);
                    else if (!updn_q && (off_q[k] != ACC_MIN)) off_q[k] <= off_q[k] - ACC_W'(1);
                end
            end
        end
    end

    always_comb begin
        offset_flat = '0;
        for (int k = 0; k < NUM_CNT; k++) offset_flat[k*ACC_W +: ACC_W] = off_q[k];
    end

    // ------------------------------------------------------------- outputs
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_FIN);
    // Gated by lock_fall so the enable drops in the same cycle lock is lost.
    assign bus.phase_en  = (state_q == ST_PULSE) && !lock_fall;
    assign bus.updn      = updn_q;
    assign bus.cntsel    = cntsel_q;
    assign bus.err       = err_q;
    assign bus.offset    = offset_flat;

endmodule

// File: tb/tb_pll_dps_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_dps_sequencer
//   Directed and random requests against pll_dps_sequencer. A PLL model
//   answers each phase_en pulse (or stalls / drops lock on command); a
//   scoreboard queue holds the expected outcome of each request and a
//   monitor compares it whenever the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_pll_dps_sequencer;

    localparam int NUM_CNT      = 3;
    localparam int STEP_W       = 10;
    localparam int ACC_W        = 10;
    localparam int PH_EN_CYCLES = 2;
    localparam int TIMEOUT      = 15;
    localparam int CNT_W        = 2;
    localparam int ACC_MAX      = 2**(ACC_W-1) - 1;
    localparam int ACC_MIN      = -(2**(ACC_W-1));

    logic scanclk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 scanclk = ~scanclk;

    pll_dps_sequencer_if #(.NUM_CNT(NUM_CNT), .STEP_W(STEP_W), .ACC_W(ACC_W)) bus();

    pll_dps_sequencer #(
        .NUM_CNT(NUM_CNT), .STEP_W(STEP_W), .ACC_W(ACC_W),
        .PH_EN_CYCLES(PH_EN_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .scanclk(scanclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int                       cnt;
        bit                       dir;
        int                       pulses;
        bit                       err;
        bit                       chk_w;
        logic [NUM_CNT*ACC_W-1:0] off;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_off[NUM_CNT];
    int   req_seq    = 0;
    int   idle_seq   = 0;
    int   stall_step = 0;
    int   lock_step  = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic finish_sim();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic int clamp(input int v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    function automatic logic [NUM_CNT*ACC_W-1:0] pack_off();
        logic [NUM_CNT*ACC_W-1:0] p;
        int                       v;
        p = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            v = exp_off[k];
            p[k*ACC_W +: ACC_W] = v[ACC_W-1:0];
        end
        return p;
    endfunction

    // ------------------------------------------------------------ PLL model
    initial begin : pll_model
        int  step, seen_seq, seen_idle, d1, d2;
        bit  prev_en;
        step = 0; seen_seq = 0; seen_idle = 0; prev_en = 0;
        bus.phase_done = 1'b1;
        bus.locked     = 1'b1;
        forever begin
            @(negedge scanclk);
            if (req_seq != seen_seq) begin
                seen_seq = req_seq;
                step     = 0;
            end
            if (idle_seq != seen_idle) begin
                seen_idle  = idle_seq;
                bus.locked = 1'b0;
                repeat (10) @(negedge scanclk);
                bus.locked = 1'b1;
            end else if (rst_n && bus.phase_en && !prev_en) begin
                step++;
                if (step == lock_step) begin
                    #2 bus.locked = 1'b0;
                    #1 check(bus.phase_en == 1'b0, "phase_en_on_lock_loss", bus.phase_en, 0);
                    repeat (10) @(negedge scanclk);
                    bus.locked = 1'b1;
                end else if (step != stall_step) begin
                    d1 = $urandom_range(1, 3);
                    d2 = $urandom_range(2, 5);
                    repeat (d1) @(negedge scanclk);
                    bus.phase_done = 1'b0;
                    repeat (d2) @(negedge scanclk);
                    bus.phase_done = 1'b1;
                end
            end
            prev_en = bus.phase_en;
        end
    end

    // -------------------------------------------------------------- monitor
    initial begin : monitor
        int   pulses, run;
        bit   prev;
        exp_t e;
        logic [7:0] act8, req8;
        pulses = 0; run = 0; prev = 0;
        forever begin
            @(negedge scanclk);
            if (!rst_n) begin
                pulses = 0; run = 0; prev = 0;
            end else begin
                if (bus.phase_en && !prev) begin
                    pulses++;
                    if (sb_q.size() == 0) begin
                        check(0, "spurious_phase_en", 1, 0);
                    end else begin
                        e    = sb_q[0];
                        act8 = {bus.cntsel, bus.updn, bus.req_ready, bus.busy};
                        req8 = {e.cnt[4:0], e.dir, 1'b0, 1'b1};
                        check(act8 == req8, "select_dir_ready_busy", act8, req8);
                    end
                end
                if (bus.phase_en) begin
                    run++;
                end else if (prev) begin
                    if (sb_q.size() > 0 && sb_q[0].chk_w)
                        check(run == PH_EN_CYCLES, "phase_en_width", run, PH_EN_CYCLES);
                    run = 0;
                end
                prev = bus.phase_en;
                if (bus.done) begin
                    if (sb_q.size() == 0) begin
                        check(0, "unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check(bus.err == e.err, "err_at_done", bus.err, e.err);
                        check(pulses == e.pulses, "phase_en_pulses", pulses, e.pulses);
                        check(bus.offset == e.off, "offset_at_done", bus.offset, e.off);
                    end
                    pulses = 0;
                end
            end
        end
    end

    // --------------------------------------------------------------- driver
    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20000) begin
            @(negedge scanclk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check(0, "done_timeout", sb_q.size(), 0);
            finish_sim();
        end
    endtask

    // plan: 0 normal, 1 PLL stalls on step 'at', 2 lock lost on step 'at'
    task automatic run_req(input int cnt, input int steps, input int plan, input int at);
        exp_t e;
        int   n, mag, bad;
        n = 0;
        while (!(bus.req_ready && bus.locked) && n < 200) begin
            @(negedge scanclk);
            n++;
        end
        if (n >= 200) begin
            check(0, "ready_timeout", 0, 1);
            finish_sim();
        end
        mag = (steps < 0) ? -steps : steps;
        if (cnt >= NUM_CNT || mag == 0) plan = 0;
        e.cnt = cnt; e.dir = (steps > 0); e.chk_w = (plan != 2);
        e.err = 1'b0; e.pulses = 0;
        if (cnt >= NUM_CNT) begin
            e.err = 1'b1;
        end else if (mag != 0) begin
            if (plan == 1) begin
                e.pulses = at; e.err = 1'b1;
                exp_off[cnt] = clamp(exp_off[cnt] + ((steps > 0) ? (at - 1) : -(at - 1)));
            end else if (plan == 2) begin
                e.pulses = at; e.err = 1'b1;
                for (int k = 0; k < NUM_CNT; k++) exp_off[k] = 0;
            end else begin
                e.pulses = mag;
                exp_off[cnt] = clamp(exp_off[cnt] + steps);
            end
        end
        e.off      = pack_off();
        stall_step = (plan == 1) ? at : 0;
        lock_step  = (plan == 2) ? at : 0;
        req_seq++;
        sb_q.push_back(e);
        bus.req_cnt   = CNT_W'(cnt);
        bus.req_steps = STEP_W'(steps);
        bus.req_valid = 1'b1;
        @(negedge scanclk);
        bus.req_valid = 1'b0;
        if (cnt >= NUM_CNT || mag == 0)
            check(bus.done == 1'b1, "done_one_cycle_after_accept", bus.done, 1);
        wait_drain();
        if (plan == 2 && !bus.locked) begin
            bad = 0;
            bus.req_cnt = '0; bus.req_steps = STEP_W'(5); bus.req_valid = 1'b1;
            repeat (3) begin
                @(negedge scanclk);
                if (bus.busy) bad++;
            end
            bus.req_valid = 1'b0;
            check(bad == 0, "req_ignored_while_unlocked", bad, 0);
        end
    endtask

    task automatic idle_lock_drop();
        int n;
        idle_seq++;
        n = 0;
        while (bus.locked && n < 20) begin
            @(negedge scanclk);
            n++;
        end
        repeat (2) @(negedge scanclk);
        for (int k = 0; k < NUM_CNT; k++) exp_off[k] = 0;
        check(bus.offset == pack_off(), "offset_cleared_idle_lock_loss", bus.offset, pack_off());
        n = 0;
        while (!bus.locked && n < 30) begin
            @(negedge scanclk);
            n++;
        end
    endtask

    initial begin : driver
        int cnt, steps, r, mag, n;
        exp_t e;
        for (int k = 0; k < NUM_CNT; k++) exp_off[k] = 0;
        bus.req_valid = 1'b0;
        bus.req_cnt   = '0;
        bus.req_steps = '0;

        #12;
        check(bus.phase_en  == 1'b0, "rst_phase_en",  bus.phase_en,  0);
        check(bus.updn      == 1'b0, "rst_updn",      bus.updn,      0);
        check(bus.cntsel    == 5'd0, "rst_cntsel",    bus.cntsel,    0);
        check(bus.busy      == 1'b0, "rst_busy",      bus.busy,      0);
        check(bus.done      == 1'b0, "rst_done",      bus.done,      0);
        check(bus.err       == 1'b0, "rst_err",       bus.err,       0);
        check(bus.offset    == '0,   "rst_offset",    bus.offset,    0);
        check(bus.req_ready == 1'b1, "rst_req_ready", bus.req_ready, 1);
        @(negedge scanclk);
        rst_n = 1'b1;
        repeat (2) @(negedge scanclk);

        run_req(1, 3, 0, 0);
        run_req(2, -512, 0, 0);
        run_req(2, -3, 0, 0);        // stays at the negative limit
        run_req(0, 0, 0, 0);
        run_req(3, 4, 0, 0);         // counter index out of range
        run_req(0, 5, 1, 2);         // PLL stalls on step 2
        run_req(0, 6, 0, 0);
        run_req(0, 4, 2, 2);         // lock lost on step 2
        run_req(1, 2, 0, 0);
        idle_lock_drop();
        run_req(0, 300, 0, 0);
        run_req(0, 300, 0, 0);       // saturates at the positive limit
        run_req(1, -1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            cnt   = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
            steps = int'($urandom_range(0, 16)) - 8;
            r     = int'($urandom_range(0, 9));
            mag   = (steps < 0) ? -steps : steps;
            if (mag == 0) r = 9;
            if (r == 0)      run_req(cnt, steps, 1, int'($urandom_range(1, mag)));
            else if (r == 1) run_req(cnt, steps, 2, int'($urandom_range(1, mag)));
            else             run_req(cnt, steps, 0, 0);
        end

        // Asynchronous reset in the middle of a request.
        n = 0;
        while (!(bus.req_ready && bus.locked) && n < 200) begin
            @(negedge scanclk);
            n++;
        end
        e.cnt = 1; e.dir = 1'b1; e.pulses = 20; e.err = 1'b0; e.chk_w = 1'b1; e.off = '0;
        stall_step = 0; lock_step = 0; req_seq++;
        sb_q.push_back(e);
        bus.req_cnt = CNT_W'(1); bus.req_steps = STEP_W'(20); bus.req_valid = 1'b1;
        @(negedge scanclk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.phase_en && n < 100) begin
            @(negedge scanclk);
            n++;
        end
        check(bus.phase_en == 1'b1, "phase_en_before_reset", bus.phase_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check(bus.phase_en  == 1'b0, "async_rst_phase_en",  bus.phase_en,  0);
        check(bus.offset    == '0,   "async_rst_offset",    bus.offset,    0);
        check(bus.busy      == 1'b0, "async_rst_busy",      bus.busy,      0);
        check(bus.req_ready == 1'b1, "async_rst_req_ready", bus.req_ready, 1);
        check(bus.cntsel    == 5'd0, "async_rst_cntsel",    bus.cntsel,    0);
        sb_q.delete();
        for (int k = 0; k < NUM_CNT; k++) exp_off[k] = 0;
        repeat (12) @(negedge scanclk);
        rst_n = 1'b1;
        repeat (2) @(negedge scanclk);
        run_req(2, 2, 0, 0);

        finish_sim();
    end

endmodule
